q2_sequencer: RTL
=================

Name: q2_sequencer

Overview:
- Upstream neighbour of q2_control: generates the state bits s0..s3 and the write strobe ws that q2_control decodes.
- Owns the instruction cycle timing, the serial-ALU bit count and the front-panel run/step/stop control.
- Every state lasts PHASE_CYCLES clocks. ws pulses high for exactly one clock at the end of each state, and the state advances on that same edge.

Parameters:
- PHASE_CYCLES, 4, clocks per state (legal range 2..16); ws is asserted in the last of them.
- ALU_BITS, 8, number of serial ALU states. Fixed encoding 0100..1011 applies when ALU_BITS=8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- run_sw  in  1  front-panel run switch (level)
- step_sw  in  1  front-panel single-step request; acted on at its rising edge
- s2in  in  1  from q2_control: 1 = enter ALU states after exec, 0 = return to fetch
- op2  in  1  opcode bit: indirect addressing (deref state performs work)
- halt  in  1  halt request, sampled at the exec-state ws
- s0, s1, s2, s3  out  1 each  state bits to q2_control
- ws  out  1  one-clock write strobe at end of each active state
- running  out  1  high while the sequencer is stepping states

Behaviour:
- Reset: {s3,s2,s1,s0}=0000 (fetch); ws=0; running=0; phase counter=0; step edge detector cleared (step_sw_d=0).
- Phase counter counts 0..PHASE_CYCLES-1 only while running=1.
  - ws = running & (phase==PHASE_CYCLES-1), registered so that it is glitch-free.
  - State update happens on the clock edge where ws=1.
- State transitions, applied at ws:
  - 0000 fetch -> 0001
  - 0001 deref -> 0010 (the state is always visited; q2_control gates the deref work on op2)
  - 0010 load -> 0011
  - 0011 exec -> 0100 if s2in=1, else 0000
  - 0100..1010 -> state+1 (serial ALU)
  - 1011 -> 0000
  - 1100..1111 are illegal -> 0000 at the next ws. The bench checks this by forcing the state register.
- Run control:
  - running sets when stopped and either run_sw=1 or a step_sw rising edge is seen. Counting starts with phase=0 on the following clock.
  - running clears at the ws that enters 0000 (instruction boundary) when any of these holds:
    - run_sw=0;
    - the current run was started by a step;
    - halt was sampled 1 at the exec ws of this instruction.
  - A latched halt_pending flag is set at the exec ws. It is cleared when the instruction boundary is reached or on rst.
  - A step edge while running is ignored and not queued.
  - run_sw dropping mid-instruction does not stop early: the instruction completes and the sequencer stops at fetch.
  - While stopped, s-bits hold 0000 and ws=0. Front-panel deposit (dep_sw in q2_control) relies on this.
- Simultaneous events:
  - rst has priority over everything.
  - A step edge in the same clock as run_sw rising is treated as a run start. The step is not latched separately.
- rst asserted mid-state: the next clock returns to the reset values; no partial ws is produced.
- Latency: the first ws appears PHASE_CYCLES clocks after running rises. One non-ALU instruction takes 4*PHASE_CYCLES clocks; an ALU instruction takes (4+ALU_BITS)*PHASE_CYCLES clocks.

Decomposition:
- Shared package q2_pkg: 4-bit state constants ST_FETCH=0000, ST_DEREF=0001, ST_LOAD=0010, ST_EXEC=0011, ST_ALU_FIRST=0100, ST_ALU_LAST=0011+ALU_BITS, and the default PHASE_CYCLES.
- One sub-module, q2_phase_timer: the phase counter and ws generator, with ports clk, rst, enable, ws.
- The state register, run/step control and halt latch stay in the top module.

Test Plan:
- Reset: hold rst 3 clocks with run_sw=1 -> s=0000, ws=0, running=0 throughout. After release, running=1 next clock; first ws at clock 4 (PHASE_CYCLES=4).
- Run, non-ALU: run_sw=1, s2in=0 -> states 0000,0001,0010,0011,0000 repeat, each 4 clocks long. Exactly one ws per state, coincident with the state change.
- ALU path: s2in=1 at exec -> 0011 -> 0100..1011 (8 states, 8 ws) -> 0000. Total instruction length 48 clocks.
- Single step: stopped, pulse step_sw for 10 clocks -> exactly one instruction (4 ws), then running=0 and s=0000. Hold step_sw high afterwards -> no second instruction until a new rising edge.
- Halt and stop: halt=1 at the exec ws -> stops at the next 0000 even with run_sw=1. Separately, drop run_sw during load -> the instruction completes and the sequencer stops at fetch.
- Mid-operation reset and illegal state: assert rst in state 0100 phase 2 -> the next clock is s=0000, ws=0. Force the state to 1110 -> the next ws goes to 0000.

Source files
------------

// File: rtl/q2_pkg.sv
// Shared state encodings and defaults for the q2 instruction sequencer.
package q2_pkg;

    localparam int unsigned PHASE_CYCLES_DEF = 4;
    localparam int unsigned ALU_BITS_DEF     = 8;

    localparam logic [3:0] ST_FETCH     = 4'b0000;
    localparam logic [3:0] ST_DEREF     = 4'b0001;
    localparam logic [3:0] ST_LOAD      = 4'b0010;
    localparam logic [3:0] ST_EXEC      = 4'b0011;
    localparam logic [3:0] ST_ALU_FIRST = 4'b0100;
    localparam logic [3:0] ST_ALU_LAST  = 4'(3 + ALU_BITS_DEF);

    typedef enum logic [1:0] {
        RC_STOPPED,
        RC_RUN,
        RC_STEP
    } run_state_e;

    function automatic logic [3:0] alu_last(input int unsigned bits);
        return 4'(3 + bits);
    endfunction

endpackage

// File: rtl/q2_sequencer_if.sv
// Front-panel controls and state-bit outputs shared between the sequencer and q2_control.
interface q2_sequencer_if;

    logic run_sw;
    logic step_sw;
    logic s2in;
    logic op2;
    logic halt;
    logic s0;
    logic s1;
    logic s2;
    logic s3;
    logic ws;
    logic running;

    modport master (
        input  run_sw, step_sw, s2in, op2, halt,
        output s0, s1, s2, s3, ws, running
    );

    modport slave (
        output run_sw, step_sw, s2in, op2, halt,
        input  s0, s1, s2, s3, ws, running
    );

endinterface

// File: rtl/q2_phase_timer.sv
// Counts clocks within a state and produces the registered end-of-state write strobe.
module q2_phase_timer
    import q2_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = PHASE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic ws
);

    localparam logic [3:0] PH_LAST    = 4'(PHASE_CYCLES - 1);
    localparam logic [3:0] PH_PRELAST = 4'(PHASE_CYCLES - 2);

    logic [3:0] r_phase;
    logic       r_ws;

    // ws is set one phase early so it rises together with phase == PH_LAST.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_phase <= '0;
            r_ws    <= 1'b0;
        end else begin
            r_ws    <= (r_phase == PH_PRELAST);
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 4'd1;
        end
    end

    assign ws = r_ws;

endmodule

// File: rtl/q2_sequencer.sv
// Instruction-cycle state sequencer with front-panel run/step/stop control and halt latch.
module q2_sequencer
    import q2_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = PHASE_CYCLES_DEF,
    parameter int unsigned ALU_BITS     = ALU_BITS_DEF
) (
    input  logic           clk,
    input  logic           rst,
    q2_sequencer_if.master bus
);

    localparam logic [3:0] ST_ALU_END = alu_last(ALU_BITS);

    logic [3:0] r_state;
    logic [3:0] w_succ;
    logic [3:0] w_state_next;
    run_state_e r_rc;
    run_state_e w_rc_next;
    logic       r_step_d;
    logic       r_halt_pend;
    logic       w_ws;
    logic       w_running;
    logic       w_step_rise;
    logic       w_boundary;
    logic       w_halt_now;
    logic       w_unused_op2;

    q2_phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (w_running),
        .ws     (w_ws)
    );

    always_comb begin
        w_succ = ST_FETCH;
        case (r_state)
            ST_FETCH: w_succ = ST_DEREF;
            ST_DEREF: w_succ = ST_LOAD;
            ST_LOAD:  w_succ = ST_EXEC;
            ST_EXEC:  w_succ = bus.s2in ? ST_ALU_FIRST : ST_FETCH;
            default: begin
                if (r_state >= ST_ALU_FIRST && r_state < ST_ALU_END) begin
                    w_succ = r_state + 4'd1;
                end
            end
        endcase
    end

    assign w_boundary   = (w_succ == ST_FETCH);
    assign w_halt_now   = (r_state == ST_EXEC) && bus.halt;
    assign w_state_next = w_ws ? w_succ : r_state;
    assign w_step_rise  = bus.step_sw & ~r_step_d;
    assign w_running    = (r_rc != RC_STOPPED);
    assign w_unused_op2 = bus.op2;

    // Halt sampled at an exec ws that itself ends the instruction must stop it too.
    always_comb begin
        w_rc_next = r_rc;
        case (r_rc)
            RC_STOPPED: begin
                if (bus.run_sw) begin
                    w_rc_next = RC_RUN;
                end else if (w_step_rise) begin
                    w_rc_next = RC_STEP;
                end
            end
            RC_RUN, RC_STEP: begin
                if (w_ws && w_boundary &&
                    (r_rc == RC_STEP || !bus.run_sw || r_halt_pend || w_halt_now)) begin
                    w_rc_next = RC_STOPPED;
                end
            end
            default: w_rc_next = RC_STOPPED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rc <= RC_STOPPED;
        end else begin
            r_rc <= w_rc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FETCH;
            r_step_d    <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_step_d <= bus.step_sw;
            if (w_ws && w_boundary) begin
                r_halt_pend <= 1'b0;
            end else if (w_ws && w_halt_now) begin
                r_halt_pend <= 1'b1;
            end
        end
    end

    assign bus.s0      = r_state[0];
    assign bus.s1      = r_state[1];
    assign bus.s2      = r_state[2];
    assign bus.s3      = r_state[3];
    assign bus.ws      = w_ws;
    assign bus.running = w_running;

endmodule
